// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer
//
// Splits one large memory transfer job into AXI-legal bursts and issues them
// one at a time to a single DMA channel over its start/addr/len/size/busy
// control interface. Each burst is limited to MAX_BURST beats and never
// crosses a BOUNDARY-byte address boundary.
//
// Optional feature macro: DMA_SEQ_ERR_EN
//   defined   : jobs with zero beats or an address not aligned to the beat
//               size are rejected at accept with a one-cycle err_o pulse.
//   undefined : address bits below the beat size are forced to zero at
//               accept, a zero-beat job completes with a done_o pulse, and
//               err_o is constant 0.
//
// Ports:
//   m_axi_aclk     in   clock
//   m_axi_aresetn  in   synchronous active-low reset
//   job_valid      in   job request valid
//   job_ready      out  job accepted when high (IDLE only)
//   job_addr       in   job start byte address
//   job_beats      in   total beats of the job
//   job_size       in   AXI size code, beat bytes = 2^job_size
//   ch_start_o     out  one-cycle burst start pulse to the channel
//   ch_addr_o      out  burst start address
//   ch_len_o       out  burst length minus one
//   ch_size_o      out  burst size code
//   ch_busy_i      in   channel busy
//   busy_o         out  job in progress
//   done_o         out  one-cycle pulse when the job completes
//   err_o          out  one-cycle pulse when a job is rejected
module dma_burst_sequencer #(
   parameter int ADDR_W    = 32,
   parameter int BEATS_W   = 20,
   parameter int MAX_BURST = 256,
   parameter int BOUNDARY  = 4096
) (
   input  logic               m_axi_aclk,
   input  logic               m_axi_aresetn,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [ADDR_W-1:0]  job_addr,
   input  logic [BEATS_W-1:0] job_beats,
   input  logic [2:0]         job_size,
   output logic               ch_start_o,
   output logic [ADDR_W-1:0]  ch_addr_o,
   output logic [7:0]         ch_len_o,
   output logic [2:0]         ch_size_o,
   input  logic               ch_busy_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   // Wide enough to hold BOUNDARY itself, not just offsets below it.
   localparam int BND_W = $clog2(BOUNDARY) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_HOLD,
      S_WAIT
   } state_t;

   state_t             state_q,   state_d;
   logic [ADDR_W-1:0]  addr_q,    addr_d;
   logic [BEATS_W-1:0] rem_q,     rem_d;
   logic [2:0]         size_q,    size_d;
   logic [8:0]         n_q,       n_d;
   logic [ADDR_W-1:0]  ch_addr_q, ch_addr_d;
   logic [7:0]         ch_len_q,  ch_len_d;
   logic [2:0]         ch_size_q, ch_size_d;
   logic               done_q,    done_d;
`ifdef DMA_SEQ_ERR_EN
   logic               err_q,     err_d;
`endif

   // Low address bits that must be zero for a beat of 2^size bytes.
   function automatic logic [ADDR_W-1:0] size_mask(input logic [2:0] size);
      return (ADDR_W'(1) << size) - ADDR_W'(1);
   endfunction

   // Next burst length: min(remaining, MAX_BURST, beats left before the
   // next boundary). Always >= 1 for a beat-aligned address.
   function automatic logic [8:0] burst_len(input logic [ADDR_W-1:0]  addr,
                                            input logic [BEATS_W-1:0] rem,
                                            input logic [2:0]         size);
      logic [BND_W-1:0] off;
      logic [BND_W-1:0] bnd;
      logic [31:0]      n;
      off = BND_W'(addr & ADDR_W'(BOUNDARY - 1));
      bnd = (BND_W'(BOUNDARY) - off) >> size;
      n   = 32'(rem);
      if (n > 32'(MAX_BURST)) n = 32'(MAX_BURST);
      if (n > 32'(bnd))       n = 32'(bnd);
      return n[8:0];
   endfunction

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      size_d     = size_q;
      n_d        = n_q;
      ch_addr_d  = ch_addr_q;
      ch_len_d   = ch_len_q;
      ch_size_d  = ch_size_q;
      done_d     = 1'b0;
`ifdef DMA_SEQ_ERR_EN
      err_d      = 1'b0;
`endif
      job_ready  = 1'b0;
      ch_start_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) begin
`ifdef DMA_SEQ_ERR_EN
               if (job_beats == '0 || (job_addr & size_mask(job_size)) != '0) begin
                  err_d = 1'b1;
               end else begin
                  addr_d  = job_addr;
                  rem_d   = job_beats;
                  size_d  = job_size;
                  state_d = S_CALC;
               end
`else
               addr_d = job_addr & ~size_mask(job_size);
               rem_d  = job_beats;
               size_d = job_size;
               // A zero-beat job finishes on the spot without a burst.
               if (job_beats == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_CALC;
               end
`endif
            end
         end

         S_CALC: begin
            n_d       = burst_len(addr_q, rem_q, size_q);
            ch_addr_d = addr_q;
            ch_len_d  = 8'(n_d - 9'd1);
            ch_size_d = size_q;
            state_d   = S_ISSUE;
         end

         S_ISSUE: begin
            if (!ch_busy_i) begin
               ch_start_o = 1'b1;
               state_d    = S_HOLD;
            end
         end

         // Gives the channel one cycle to raise busy after the start pulse.
         S_HOLD: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (!ch_busy_i) begin
               addr_d = addr_q + (ADDR_W'(n_q) << size_q);
               rem_d  = rem_q - BEATS_W'(n_q);
               if (rem_d == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         size_q    <= '0;
         n_q       <= '0;
         ch_addr_q <= '0;
         ch_len_q  <= '0;
         ch_size_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         size_q    <= size_d;
         n_q       <= n_d;
         ch_addr_q <= ch_addr_d;
         ch_len_q  <= ch_len_d;
         ch_size_q <= ch_size_d;
         done_q    <= done_d;
      end
   end

`ifdef DMA_SEQ_ERR_EN
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = done_q;
   assign ch_addr_o = ch_addr_q;
   assign ch_len_o  = ch_len_q;
   assign ch_size_o = ch_size_q;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Testbench for dma_burst_sequencer: a channel model answers each start pulse
// with a busy window, and a job-level model predicts the burst list and the
// cycle on which every start, done and err pulse must appear.
module tb_dma_burst_sequencer;

   localparam int ADDR_W    = 32;
   localparam int BEATS_W   = 20;
   localparam int MAX_BURST = 256;
   localparam int BOUNDARY  = 4096;
`ifdef DMA_SEQ_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } burst_t;
   typedef burst_t bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               aresetn;
   logic               job_valid;
   logic               job_ready;
   logic [ADDR_W-1:0]  job_addr;
   logic [BEATS_W-1:0] job_beats;
   logic [2:0]         job_size;
   logic               ch_start_o;
   logic [ADDR_W-1:0]  ch_addr_o;
   logic [7:0]         ch_len_o;
   logic [2:0]         ch_size_o;
   logic               ch_busy_i;
   logic               busy_o;
   logic               done_o;
   logic               err_o;

   logic chan_busy;
   logic ext_busy;
   int   chan_dur;
   assign ch_busy_i = chan_busy | ext_busy;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   bq_t  exp_q;
   bq_t  obs_q;
   bq_t  pl;

   bit   m_busy, m_infl, m_hold, m_pend_done, m_pend_err;
   int   m_cnt;

   dma_burst_sequencer #(
      .ADDR_W   (ADDR_W),
      .BEATS_W  (BEATS_W),
      .MAX_BURST(MAX_BURST),
      .BOUNDARY (BOUNDARY)
   ) dut (
      .m_axi_aclk   (clk),
      .m_axi_aresetn(aresetn),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_addr     (job_addr),
      .job_beats    (job_beats),
      .job_size     (job_size),
      .ch_start_o   (ch_start_o),
      .ch_addr_o    (ch_addr_o),
      .ch_len_o     (ch_len_o),
      .ch_size_o    (ch_size_o),
      .ch_busy_i    (ch_busy_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Burst list of a job worked out directly from the splitting rules.
   function automatic bq_t plan_job(input logic [31:0] addr, input int beats, input int size);
      bq_t    q;
      longint a;
      int     rem, n, bnd;
      logic [31:0] al;
      burst_t b;
      al  = addr & ~((32'd1 << size) - 32'd1);
      a   = longint'(al);
      rem = beats;
      while (rem > 0) begin
         bnd = (BOUNDARY - int'(a % BOUNDARY)) >> size;
         n = rem;
         if (n > MAX_BURST) n = MAX_BURST;
         if (n > bnd)       n = bnd;
         b.addr = a[31:0];
         b.len  = 8'(n - 1);
         b.size = 3'(size);
         q.push_back(b);
         a   = (a + (longint'(n) << size)) % 64'h1_0000_0000;
         rem = rem - n;
      end
      return q;
   endfunction

   // Channel: busy from the cycle after a start for chan_dur cycles
   // (random 1..6 when chan_dur is 0).
   initial begin
      int d;
      chan_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (ch_start_o && aresetn) begin
            d = (chan_dur > 0) ? chan_dur : int'($urandom_range(1, 6));
            @(posedge clk);
            #1 chan_busy = 1'b1;
            repeat (d) @(posedge clk);
            #1 chan_busy = 1'b0;
         end
      end
   end

   // Compare process: job-level model, checked every cycle.
   initial begin
      bit exp_start, was_busy, bad;
      m_busy = 0; m_infl = 0; m_hold = 0; m_pend_done = 0; m_pend_err = 0; m_cnt = 0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            m_busy = 0; m_infl = 0; m_hold = 0; m_pend_done = 0; m_pend_err = 0; m_cnt = 0;
            exp_q.delete();
         end else begin
            if (m_cnt > 0) m_cnt--;
            exp_start = m_busy && !m_infl && (m_cnt == 0) && !ch_busy_i && (exp_q.size() > 0);
            chk("ch_start", 32'(ch_start_o), 32'(exp_start));
            chk("done", 32'(done_o), 32'(m_pend_done));
            chk("err", 32'(err_o), 32'(m_pend_err));
            chk("busy", 32'(busy_o), 32'(m_busy));
            chk("job_ready", 32'(job_ready), 32'(!m_busy));
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
            if (ch_start_o) obs_q.push_back('{ch_addr_o, ch_len_o, ch_size_o});
            was_busy    = m_busy;
            m_pend_done = 0;
            m_pend_err  = 0;
            if (exp_start) begin
               chk("burst_addr", ch_addr_o, exp_q[0].addr);
               chk("burst_len", 32'(ch_len_o), 32'(exp_q[0].len));
               chk("burst_size", 32'(ch_size_o), 32'(exp_q[0].size));
               void'(exp_q.pop_front());
               m_infl = 1;
               m_hold = 1;
            end else if (m_infl) begin
               if (m_hold) begin
                  m_hold = 0;
               end else if (!ch_busy_i) begin
                  m_infl = 0;
                  if (exp_q.size() == 0) begin
                     m_pend_done = 1;
                     m_busy      = 0;
                  end else begin
                     m_cnt = 2;
                  end
               end
            end
            if (job_valid && !was_busy) begin
               bad = ERR_EN && ((job_beats == '0) ||
                                ((job_addr & ((32'd1 << job_size) - 32'd1)) != '0));
               if (bad) begin
                  m_pend_err = 1;
               end else if (job_beats == '0) begin
                  m_pend_done = 1;
               end else begin
                  exp_q  = plan_job(job_addr, int'(job_beats), int'(job_size));
                  m_busy = 1;
                  m_cnt  = 2;
               end
            end
         end
      end
   end

   task automatic run_job(input logic [31:0] a, input int b, input int s);
      @(posedge clk);
      #1;
      job_valid = 1'b1;
      job_addr  = a;
      job_beats = 20'(b);
      job_size  = 3'(s);
      @(posedge clk);
      #1 job_valid = 1'b0;
   endtask

   task automatic wait_job(input int limit);
      int k;
      k = 0;
      repeat (3) @(negedge clk);
      while ((busy_o || chan_busy) && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("job_finished_in_time", 32'(k < limit), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_obs(input string name, input int idx, input logic [31:0] a,
                          input logic [7:0] l, input logic [2:0] s);
      if (idx < obs_q.size()) begin
         chk({name, "_addr"}, obs_q[idx].addr, a);
         chk({name, "_len"}, 32'(obs_q[idx].len), 32'(l));
         chk({name, "_size"}, 32'(obs_q[idx].size), 32'(s));
      end else begin
         chk({name, "_present"}, 32'(obs_q.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, e0, k;
      aresetn   = 1'b0;
      job_valid = 1'b0;
      job_addr  = '0;
      job_beats = '0;
      job_size  = '0;
      ext_busy  = 1'b0;
      chan_dur  = 5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_job_ready", 32'(job_ready), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_start", 32'(ch_start_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_addr", ch_addr_o, 32'd0);
      chk("rst_len", 32'(ch_len_o), 32'd0);
      chk("rst_size", 32'(ch_size_o), 32'd0);

      // Pin the model against hand-computed burst lists.
      pl = plan_job(32'h0, 600, 3);
      chk("pin600_count", 32'(pl.size()), 32'd3);
      if (pl.size() == 3) begin
         chk("pin600_a1", pl[1].addr, 32'h800);
         chk("pin600_a2", pl[2].addr, 32'h1000);
         chk("pin600_l2", 32'(pl[2].len), 32'd87);
      end
      pl = plan_job(32'hFF0, 10, 3);
      chk("pinFF0_count", 32'(pl.size()), 32'd2);
      if (pl.size() == 2) begin
         chk("pinFF0_l0", 32'(pl[0].len), 32'd1);
         chk("pinFF0_l1", 32'(pl[1].len), 32'd7);
      end

      @(posedge clk);
      #1 aresetn = 1'b1;
      repeat (2) @(negedge clk);

      // Single burst, channel busy 5 cycles.
      obs_q.delete(); d0 = done_cnt;
      run_job(32'h1000, 16, 3);
      wait_job(2000);
      chk("t1_starts", 32'(obs_q.size()), 32'd1);
      chk_obs("t1_b0", 0, 32'h1000, 8'd15, 3'd3);
      chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
      chk("t1_busy_idle", 32'(busy_o), 32'd0);

      // Three bursts limited by MAX_BURST.
      obs_q.delete(); d0 = done_cnt;
      run_job(32'h0, 600, 3);
      wait_job(2000);
      chk("t2_starts", 32'(obs_q.size()), 32'd3);
      chk_obs("t2_b0", 0, 32'h0, 8'd255, 3'd3);
      chk_obs("t2_b1", 1, 32'h800, 8'd255, 3'd3);
      chk_obs("t2_b2", 2, 32'h1000, 8'd87, 3'd3);
      chk("t2_done_count", 32'(done_cnt - d0), 32'd1);

      // Split at a 4 KB boundary.
      obs_q.delete(); d0 = done_cnt;
      run_job(32'hFF0, 10, 3);
      wait_job(2000);
      chk("t3_starts", 32'(obs_q.size()), 32'd2);
      chk_obs("t3_b0", 0, 32'hFF0, 8'd1, 3'd3);
      chk_obs("t3_b1", 1, 32'h1000, 8'd7, 3'd3);
      chk("t3_done_count", 32'(done_cnt - d0), 32'd1);

      // Channel held busy externally before the first issue.
      obs_q.delete();
      @(posedge clk);
      #1 ext_busy = 1'b1;
      run_job(32'h2000, 4, 2);
      repeat (18) @(posedge clk);
      chk("t4_no_start_while_busy", 32'(obs_q.size()), 32'd0);
      #1 ext_busy = 1'b0;
      wait_job(2000);
      chk("t4_starts", 32'(obs_q.size()), 32'd1);
      chk_obs("t4_b0", 0, 32'h2000, 8'd3, 3'd2);

      // Address wraps past the top of the address space.
      obs_q.delete();
      run_job(32'hFFFF_FFF0, 4, 3);
      wait_job(2000);
      chk_obs("t5_b0", 0, 32'hFFFF_FFF0, 8'd1, 3'd3);
      chk_obs("t5_b1", 1, 32'h0, 8'd1, 3'd3);

      // Reset during WAIT of the second burst.
      obs_q.delete(); chan_dur = 5;
      run_job(32'h0, 600, 3);
      k = 0;
      while (obs_q.size() < 2 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("t6_second_start_seen", 32'(k < 3000), 32'd1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 aresetn = 1'b0;
      @(posedge clk);
      #1 aresetn = 1'b1;
      @(negedge clk);
      chk("t6_job_ready", 32'(job_ready), 32'd1);
      chk("t6_busy", 32'(busy_o), 32'd0);
      chk("t6_start", 32'(ch_start_o), 32'd0);
      chk("t6_done", 32'(done_o), 32'd0);
      chk("t6_addr", ch_addr_o, 32'd0);
      chk("t6_len", 32'(ch_len_o), 32'd0);
      repeat (40) @(negedge clk);
      chk("t6_no_more_starts", 32'(obs_q.size()), 32'd2);
      wait_job(2000);
      run_job(32'h3000, 8, 2);
      wait_job(2000);
      chk("t6_starts_after", 32'(obs_q.size()), 32'd3);
      chk_obs("t6_new", 2, 32'h3000, 8'd7, 3'd2);

      // Misaligned address.
      obs_q.delete(); d0 = done_cnt; e0 = err_cnt;
      run_job(32'h1004, 4, 3);
      wait_job(2000);
      if (ERR_EN) begin
         chk("t7_err_count", 32'(err_cnt - e0), 32'd1);
         chk("t7_no_start", 32'(obs_q.size()), 32'd0);
         chk("t7_no_done", 32'(done_cnt - d0), 32'd0);
      end else begin
         chk_obs("t7_aligned", 0, 32'h1000, 8'd3, 3'd3);
         chk("t7_done_count", 32'(done_cnt - d0), 32'd1);
      end

      // Zero-beat job.
      obs_q.delete(); d0 = done_cnt; e0 = err_cnt;
      run_job(32'h4000, 0, 2);
      wait_job(2000);
      chk("t8_no_start", 32'(obs_q.size()), 32'd0);
      if (ERR_EN) chk("t8_err_count", 32'(err_cnt - e0), 32'd1);
      else        chk("t8_done_count", 32'(done_cnt - d0), 32'd1);

      // Randomized jobs, random channel latency.
      chan_dur = 0;
      for (int j = 0; j < 25; j++) begin
         logic [31:0] a;
         int b, s;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[11:0] = {4'hF, 8'($urandom_range(0, 255))};
         b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 700));
         s = int'($urandom_range(0, 3));
         run_job(a, b, s);
         wait_job(5000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_burst_sequencer.md
Name: dma_burst_sequencer

Overview:
- Splits one large memory transfer job into a series of AXI-legal bursts and issues them one at a time to a single DMA channel (read or write) over its start/addr/len/size/busy control interface.
- Sits directly upstream of the DMA channel control inputs and takes the place of register-driven single-burst starts.
- Each burst is limited by MAX_BURST and must not cross a BOUNDARY-byte address boundary.
- One sequencer instance is used per channel (mm2s and s2mm).

Parameters:
- ADDR_W, 32, width of the byte address (matches DMA_AXI_ADDR_WIDTH).
- BEATS_W, 20, width of the job beat count.
- MAX_BURST, 256, maximum beats per burst; legal range 1..256.
- BOUNDARY, 4096, address boundary in bytes that no burst may cross; must be a power of two.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  synchronous active-low reset
- job_valid  in  1  job request valid
- job_ready  out  1  sequencer accepts a job (high only in IDLE)
- job_addr  in  ADDR_W  start byte address
- job_beats  in  BEATS_W  total beats to transfer
- job_size  in  3  AXI size code; beat bytes = 2^job_size
- ch_start_o  out  1  one-cycle burst start pulse to the channel
- ch_addr_o  out  ADDR_W  burst start address
- ch_len_o  out  8  burst length minus one
- ch_size_o  out  3  size code (registered copy of job_size)
- ch_busy_i  in  1  channel busy
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse when the last burst completes
- err_o  out  1  one-cycle error pulse (feature-dependent, see Optional Feature)

Behaviour:
- Reset (m_axi_aresetn=0 sampled at a clock edge):
  - State goes to IDLE.
  - All outputs are 0 except job_ready=1.
  - Internal addr/remaining/size registers are cleared.
  - Reset mid-job abandons the job immediately. No further start pulses are issued; a burst already running in the channel is not tracked.
- States: IDLE, CALC, ISSUE, HOLD, WAIT.
- IDLE:
  - job_ready=1.
  - On job_valid&&job_ready: latch addr, beats (as remaining) and size; go to CALC.
  - job_beats==0 at accept: done_o pulses the next cycle and the state returns to IDLE; no burst is issued.
- CALC (1 cycle): compute the next burst length n = min(remaining, MAX_BURST, bnd).
  - bnd = (BOUNDARY − (addr mod BOUNDARY)) >> size.
  - n ≥ 1 always holds for an aligned address.
  - Register ch_addr_o=addr, ch_len_o=n−1, ch_size_o=size.
  - Store n internally; go to ISSUE.
- ISSUE:
  - If ch_busy_i=0: ch_start_o=1 for exactly this cycle, then go to HOLD.
  - If ch_busy_i=1: wait in ISSUE with ch_start_o=0.
- HOLD (1 cycle):
  - ch_busy_i is ignored.
  - Channel contract: busy rises no later than the cycle after the start pulse.
- WAIT:
  - When ch_busy_i=0: addr += n<<size; remaining −= n.
  - If remaining==0: done_o=1 for one cycle, go to IDLE. Otherwise go to CALC.
- ch_addr_o, ch_len_o and ch_size_o stay stable from CALC until the next CALC.
- busy_o=1 in every state except IDLE.
- Address increment wraps modulo 2^ADDR_W; this is not flagged.
- Overhead between bursts: 3 cycles (WAIT exit → CALC → ISSUE).
- job_valid is ignored outside IDLE.
- Without DMA_SEQ_ERR_EN, err_o is tied 0.

Optional Feature:
- Macro: DMA_SEQ_ERR_EN.
- Defined:
  - At accept, a job with job_beats==0 or with job_addr not aligned to 2^job_size is rejected.
  - On rejection: err_o pulses one cycle after accept, done_o stays 0, no burst is issued, and the state returns to IDLE.
- Undefined:
  - Address low bits below the size are forced to 0 at latch (silent alignment).
  - A zero-beat job completes with done_o as described in Behaviour.
  - err_o is constant 0.

Test Plan:
- job_addr=0x1000, beats=16, size=3; channel busy for 5 cycles after each start → one start with addr=0x1000, len=15; done_o pulses once; busy_o returns to 0.
- addr=0x0, beats=600, size=3 → bursts of len 255, 255, 87 at addr 0x0, 0x800 and 0x1000 in that order; exactly 3 start pulses.
- addr=0x0FF0, beats=10, size=3 (4 KB boundary at 0x1000) → burst addr=0xFF0 len=1, then addr=0x1000 len=7; done_o pulses after the second burst.
- ch_busy_i held high for 20 cycles from an external source before ISSUE → no start pulse while busy; start issued on the first cycle busy=0.
- Assert m_axi_aresetn=0 for one cycle during WAIT of the second burst of a 600-beat job → all outputs 0, job_ready=1; no further starts; a new job runs normally afterwards.
- DMA_SEQ_ERR_EN defined, addr=0x1004, size=3 → err_o pulse, no start, done_o stays 0. Undefined: same stimulus → first burst addr=0x1000.
